// File: rtl/kbd_serial_link_if.sv
// Host-side byte bus of the keyboard/ADB serial link: response bytes toward
// the Mac and command bytes received from it.
interface kbd_serial_link_if #(
  parameter int FRAME_BITS = 8
);
  logic [FRAME_BITS-1:0] host_din;
  logic                  host_din_strobe;
  logic [FRAME_BITS-1:0] cmd_dout;
  logic                  cmd_strobe;

  modport master (
    output host_din,
    output host_din_strobe,
    input  cmd_dout,
    input  cmd_strobe
  );

  modport slave (
    input  host_din,
    input  host_din_strobe,
    output cmd_dout,
    output cmd_strobe
  );
endinterface

// File: rtl/kbd_serial_link.sv
// Keyboard/ADB bit-serial engine between the VIA shift register (CB1/CB2)
// and the keyboard/ADB front ends, with a response FIFO and wait timeout.
module kbd_serial_link #(
  parameter int FRAME_BITS = 8,
  parameter int DIV_PLUS   = 1300,
  parameter int DIV_ADB    = 80,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 32000
) (
  input  logic                        clk32,
  input  logic                        _reset,
  input  logic                        clk8_en_p,
  input  logic                        mode,
  input  logic                        dat_from_via,
  input  logic                        adb_listen,
  kbd_serial_link_if.slave            host,
  output logic                        kbdclk,
  output logic                        kbddata_o,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  output logic                        timeout
);

  localparam int PW      = $clog2(FIFO_DEPTH);
  localparam int CNTW    = PW + 1;
  localparam int DIV_MAX = (DIV_PLUS > DIV_ADB) ? DIV_PLUS : DIV_ADB;
  localparam int CW      = (DIV_MAX < 2) ? 1 : $clog2(DIV_MAX);
  localparam int BW      = (FRAME_BITS < 2) ? 1 : $clog2(FRAME_BITS);
  localparam int TOW     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  localparam logic [CW-1:0]   DIVP_M1  = CW'(DIV_PLUS - 1);
  localparam logic [CW-1:0]   DIVA_M1  = CW'(DIV_ADB - 1);
  localparam logic [BW-1:0]   LAST_BIT = BW'(FRAME_BITS - 1);
  localparam logic [TOW-1:0]  TO_M1    = TOW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, TX, WAIT_RX, RX} state_t;

  state_t                r_state;
  logic                  r_mode_q;
  logic [CW-1:0]         r_cnt;
  logic [BW-1:0]         r_bitcnt;
  logic [TOW-1:0]        r_tcnt;
  logic [FRAME_BITS-1:0] r_shift;
  logic                  r_kbdclk;
  logic                  r_kbddata;
  logic                  r_busy;
  logic                  r_overflow;
  logic                  r_timeout;
  logic [FRAME_BITS-1:0] r_cmd_dout;
  logic                  r_cmd_strobe;
  logic                  r_listen;
  logic                  r_listen_d;
  logic [FRAME_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CNTW-1:0]       r_count;

  logic [CW-1:0]         w_div_m1;
  logic                  w_edge;
  logic                  w_fall;
  logic                  w_rise;
  logic                  w_tx_start;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_wr;
  logic [FRAME_BITS-1:0] w_head;

  // A pop frees a slot in the same tick, so a push while full still lands
  always_comb begin
    w_div_m1   = r_mode_q ? DIVA_M1 : DIVP_M1;
    w_edge     = (r_cnt == w_div_m1);
    w_fall     = w_edge & r_kbdclk;
    w_rise     = w_edge & ~r_kbdclk;
    w_tx_start = (r_state == IDLE) &&
                 (mode ? (r_listen & ~r_listen_d) : ~dat_from_via);
    w_empty    = (r_count == '0);
    w_full     = (r_count == FULL_CNT);
    w_pop      = clk8_en_p && !w_empty &&
                 (((r_state == IDLE) && mode && !w_tx_start) ||
                  ((r_state == WAIT_RX) && dat_from_via));
    w_push     = clk8_en_p && host.host_din_strobe;
    w_wr       = w_push && (!w_full || w_pop);
    w_head     = r_mem[r_rd_ptr];
  end

  always_ff @(posedge clk32) begin
    if (w_wr) r_mem[r_wr_ptr] <= host.host_din;
  end

  always_ff @(posedge clk32 or negedge _reset) begin
    if (!_reset) begin
      r_state      <= IDLE;
      r_mode_q     <= 1'b0;
      r_cnt        <= '0;
      r_bitcnt     <= '0;
      r_tcnt       <= '0;
      r_shift      <= '0;
      r_kbdclk     <= 1'b1;
      r_kbddata    <= 1'b1;
      r_busy       <= 1'b0;
      r_overflow   <= 1'b0;
      r_timeout    <= 1'b0;
      r_cmd_dout   <= '0;
      r_cmd_strobe <= 1'b0;
      r_listen     <= 1'b0;
      r_listen_d   <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
    end else begin
      r_cmd_strobe <= 1'b0;
      r_timeout    <= 1'b0;
      if (clk8_en_p) begin
        r_listen   <= adb_listen;
        r_listen_d <= r_listen;
        if (w_wr)   r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        r_count <= r_count + {{PW{1'b0}}, w_wr} - {{PW{1'b0}}, w_pop};
        if (w_push && !w_wr) r_overflow <= 1'b1;

        case (r_state)
          IDLE: begin
            r_cnt    <= '0;
            r_kbdclk <= 1'b1;
            r_bitcnt <= '0;
            if (w_tx_start) begin
              r_state  <= TX;
              r_mode_q <= mode;
              r_busy   <= 1'b1;
            end else if (w_pop) begin
              r_state  <= RX;
              r_mode_q <= mode;
              r_shift  <= w_head;
              r_busy   <= 1'b1;
            end
          end

          TX, RX: begin
            if (w_edge) begin
              r_cnt    <= '0;
              r_kbdclk <= ~r_kbdclk;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
            if (w_fall) begin
              if (r_state == TX) r_shift   <= {r_shift[FRAME_BITS-2:0], dat_from_via};
              else               r_kbddata <= r_shift[LAST_BIT - r_bitcnt];
            end
            if (w_rise) begin
              if (r_bitcnt == LAST_BIT) begin
                r_bitcnt <= '0;
                if (r_state == TX) begin
                  r_cmd_dout   <= r_shift;
                  r_cmd_strobe <= 1'b1;
                  if (r_mode_q) begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                  end else begin
                    r_state <= WAIT_RX;
                    r_tcnt  <= '0;
                  end
                end else begin
                  r_state   <= IDLE;
                  r_kbddata <= 1'b1;
                  r_busy    <= 1'b0;
                end
              end else begin
                r_bitcnt <= r_bitcnt + 1'b1;
              end
            end
          end

          WAIT_RX: begin
            r_cnt    <= '0;
            r_kbdclk <= 1'b1;
            if (w_pop) begin
              r_state <= RX;
              r_shift <= w_head;
            end else if ((TIMEOUT != 0) && (r_tcnt == TO_M1)) begin
              r_timeout <= 1'b1;
              r_state   <= IDLE;
              r_busy    <= 1'b0;
            end else begin
              r_tcnt <= r_tcnt + 1'b1;
            end
          end

          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign kbdclk          = r_kbdclk;
  assign kbddata_o       = r_kbddata;
  assign busy            = r_busy;
  assign fifo_count      = r_count;
  assign overflow        = r_overflow;
  assign timeout         = r_timeout;
  assign host.cmd_dout   = r_cmd_dout;
  assign host.cmd_strobe = r_cmd_strobe;

endmodule

// File: tb/tb_kbd_serial_link.sv
// Directed bench for kbd_serial_link: Plus and ADB frames, FIFO limits,
// wait timeout and mid-frame reset.
module tb_kbd_serial_link;
  localparam int DIVP = 4;
  localparam int DIVA = 2;

  logic       clk32 = 1'b0;
  logic       rst_n;
  logic       clk8_en_p;
  logic [1:0] ph = 2'd0;
  logic       mode;
  logic       dat;
  logic       listen;
  logic       kbdclk;
  logic       kbddata_o;
  logic       busy;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  kbd_serial_link_if #(.FRAME_BITS(8)) host ();

  kbd_serial_link #(
    .FRAME_BITS(8),
    .DIV_PLUS  (DIVP),
    .DIV_ADB   (DIVA),
    .FIFO_DEPTH(4),
    .TIMEOUT   (10)
  ) dut (
    .clk32       (clk32),
    ._reset      (rst_n),
    .clk8_en_p   (clk8_en_p),
    .mode        (mode),
    .dat_from_via(dat),
    .adb_listen  (listen),
    .host        (host.slave),
    .kbdclk      (kbdclk),
    .kbddata_o   (kbddata_o),
    .busy        (busy),
    .fifo_count  (fifo_count),
    .overflow    (overflow),
    .timeout     (timeout)
  );

  always #5 clk32 = ~clk32;
  always @(posedge clk32) ph <= ph + 2'd1;
  assign clk8_en_p = (ph == 2'd3);

  task automatic tick();
    do @(posedge clk32); while (clk8_en_p !== 1'b1);
    #1;
  endtask

  task automatic push_tick(input logic [7:0] b);
    host.host_din        = b;
    host.host_din_strobe = 1'b1;
    tick();
    host.host_din_strobe = 1'b0;
  endtask

  // Drives the Mac-side bits of b, one per bit period, starting on the tick after entry
  task automatic run_tx(input logic [7:0] b, input int div, output int strobe_at,
                        output logic [7:0] dout, output logic clk_at_div);
    strobe_at  = -1;
    dout       = '0;
    clk_at_div = 1'bx;
    for (int t = 1; t <= 16 * div; t++) begin
      dat = b[7 - ((t - 1) / (2 * div))];
      tick();
      if (t == div) clk_at_div = kbdclk;
      if (host.cmd_strobe === 1'b1 && strobe_at < 0) begin
        strobe_at = t;
        dout      = host.cmd_dout;
      end
    end
  endtask

  task automatic run_rx(input logic [7:0] exp, input int div, input string name);
    logic [7:0] got = '0;
    logic       clk_ok = 1'b1;
    for (int t = 1; t <= 16 * div; t++) begin
      tick();
      if ((t % (2 * div)) == div) begin
        got = {got[6:0], kbddata_o};
        if (kbdclk !== 1'b0) clk_ok = 1'b0;
      end
    end
    checks++;
    if (got !== exp || clk_ok !== 1'b1) begin
      errors++;
      $display("FAIL %s_bits: got %h clk_ok %b expected %h clk_ok 1", name, got, clk_ok, exp);
    end
    checks++;
    if (busy !== 1'b0 || kbddata_o !== 1'b1) begin
      errors++;
      $display("FAIL %s_end: busy %b kbddata %b expected busy 0 kbddata 1", name, busy, kbddata_o);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk32);
    #1;
    checks++;
    if ({kbdclk, kbddata_o, busy, fifo_count, overflow, timeout, host.cmd_strobe, host.cmd_dout} !== {1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_vals: clk %b data %b busy %b cnt %0d ovf %b to %b stb %b dout %h expected 1 1 0 0 0 0 0 00",
               kbdclk, kbddata_o, busy, fifo_count, overflow, timeout, host.cmd_strobe, host.cmd_dout);
    end
    @(negedge clk32) rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0 || kbdclk !== 1'b1 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL idle_after_reset: busy %b clk %b cnt %0d expected 0 1 0", busy, kbdclk, fifo_count);
    end
  endtask

  task automatic test_plus_tx();
    int sa; logic [7:0] d; logic c;
    mode = 1'b0;
    dat  = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL plus_tx_busy: got %b expected 1", busy); end
    run_tx(8'h14, DIVP, sa, d, c);
    dat = 1'b1;
    checks++;
    if (c !== 1'b0) begin errors++; $display("FAIL plus_first_fall: kbdclk %b expected 0", c); end
    checks++;
    if (sa !== 64 || d !== 8'h14) begin
      errors++; $display("FAIL plus_tx_strobe: tick %0d dout %h expected tick 64 dout 14", sa, d);
    end
    checks++;
    if (busy !== 1'b1 || kbdclk !== 1'b1) begin
      errors++; $display("FAIL plus_wait_rx: busy %b clk %b expected 1 1", busy, kbdclk);
    end
  endtask

  task automatic test_plus_response();
    push_tick(8'h7B);
    checks++;
    if (fifo_count !== 3'd1) begin errors++; $display("FAIL plus_push: count %0d expected 1", fifo_count); end
    tick();
    checks++;
    if (fifo_count !== 3'd0 || busy !== 1'b1) begin
      errors++; $display("FAIL plus_rx_start: count %0d busy %b expected 0 1", fifo_count, busy);
    end
    run_rx(8'h7B, DIVP, "plus_rx");
    checks++;
    if (fifo_count !== 3'd0) begin errors++; $display("FAIL plus_rx_count: count %0d expected 0", fifo_count); end
  endtask

  task automatic test_timeout();
    int sa; logic [7:0] d; logic c;
    dat = 1'b0;
    tick();
    run_tx(8'hC3, DIVP, sa, d, c);
    dat = 1'b1;
    checks++;
    if (sa !== 64 || d !== 8'hC3) begin
      errors++; $display("FAIL to_tx_strobe: tick %0d dout %h expected tick 64 dout c3", sa, d);
    end
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 9) begin
        checks++;
        if (timeout !== 1'b0 || busy !== 1'b1) begin
          errors++; $display("FAIL to_early: timeout %b busy %b expected 0 1", timeout, busy);
        end
      end
    end
    checks++;
    if (timeout !== 1'b1 || busy !== 1'b0 || kbdclk !== 1'b1) begin
      errors++; $display("FAIL to_pulse: timeout %b busy %b clk %b expected 1 0 1", timeout, busy, kbdclk);
    end
    tick();
    checks++;
    if (timeout !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL to_after: timeout %b busy %b expected 0 0", timeout, busy);
    end
  endtask

  task automatic test_adb();
    int sa; logic [7:0] d; logic c;
    mode   = 1'b1;
    dat    = 1'b1;
    listen = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL adb_no_early_start: busy %b expected 0", busy); end
    tick();
    listen = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL adb_tx_busy: busy %b expected 1", busy); end
    run_tx(8'h3C, DIVA, sa, d, c);
    dat = 1'b1;
    checks++;
    if (sa !== 32 || d !== 8'h3C || busy !== 1'b0) begin
      errors++; $display("FAIL adb_tx_strobe: tick %0d dout %h busy %b expected tick 32 dout 3c busy 0", sa, d, busy);
    end
    push_tick(8'hA5);
    checks++;
    if (fifo_count !== 3'd1 || busy !== 1'b0) begin
      errors++; $display("FAIL adb_push_empty: count %0d busy %b expected 1 0", fifo_count, busy);
    end
    push_tick(8'h5A);
    checks++;
    if (fifo_count !== 3'd1 || busy !== 1'b1) begin
      errors++; $display("FAIL adb_rx_start: count %0d busy %b expected 1 1", fifo_count, busy);
    end
    run_rx(8'hA5, DIVA, "adb_rx1");
    tick();
    checks++;
    if (fifo_count !== 3'd0 || busy !== 1'b1) begin
      errors++; $display("FAIL adb_back_to_back: count %0d busy %b expected 0 1", fifo_count, busy);
    end
    run_rx(8'h5A, DIVA, "adb_rx2");
  endtask

  task automatic test_fifo_boundary();
    logic [7:0] order [4];
    order[0] = 8'h22; order[1] = 8'h33; order[2] = 8'h44; order[3] = 8'h66;
    mode = 1'b0;
    dat  = 1'b1;
    push_tick(8'h11);
    push_tick(8'h22);
    push_tick(8'h33);
    push_tick(8'h44);
    checks++;
    if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
      errors++; $display("FAIL fifo_full: count %0d ovf %b expected 4 0", fifo_count, overflow);
    end
    push_tick(8'h55);
    checks++;
    if (fifo_count !== 3'd4 || overflow !== 1'b1) begin
      errors++; $display("FAIL fifo_overflow: count %0d ovf %b expected 4 1", fifo_count, overflow);
    end
    mode = 1'b1;
    push_tick(8'h66);
    checks++;
    if (fifo_count !== 3'd4 || busy !== 1'b1) begin
      errors++; $display("FAIL fifo_push_pop_full: count %0d busy %b expected 4 1", fifo_count, busy);
    end
    run_rx(8'h11, DIVA, "fifo_rx0");
    for (int i = 0; i < 4; i++) begin
      tick();
      run_rx(order[i], DIVA, $sformatf("fifo_rx%0d", i + 1));
    end
    checks++;
    if (fifo_count !== 3'd0) begin errors++; $display("FAIL fifo_drain: count %0d expected 0", fifo_count); end
  endtask

  task automatic test_reset_mid_tx();
    int sa; logic [7:0] d; logic c; logic [7:0] b;
    b    = 8'h96;
    mode = 1'b0;
    dat  = 1'b0;
    tick();
    for (int t = 1; t <= 29; t++) begin
      dat = b[7 - ((t - 1) / (2 * DIVP))];
      host.host_din        = 8'h99;
      host.host_din_strobe = (t == 1);
      tick();
    end
    host.host_din_strobe = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({kbdclk, kbddata_o, busy, fifo_count, overflow, host.cmd_strobe} !== {1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_tx: clk %b data %b busy %b cnt %0d ovf %b stb %b expected 1 1 0 0 0 0",
               kbdclk, kbddata_o, busy, fifo_count, overflow, host.cmd_strobe);
    end
    dat = 1'b1;
    repeat (3) @(posedge clk32);
    @(negedge clk32) rst_n = 1'b1;
    repeat (2) tick();
    dat = 1'b0;
    tick();
    run_tx(8'h5A, DIVP, sa, d, c);
    dat = 1'b1;
    checks++;
    if (sa !== 64 || d !== 8'h5A || busy !== 1'b1) begin
      errors++; $display("FAIL fresh_tx: tick %0d dout %h busy %b expected tick 64 dout 5a busy 1", sa, d, busy);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    mode                 = 1'b0;
    dat                  = 1'b1;
    listen               = 1'b0;
    host.host_din        = '0;
    host.host_din_strobe = 1'b0;
    test_reset();
    test_plus_tx();
    test_plus_response();
    test_timeout();
    test_adb();
    test_fifo_boundary();
    test_reset_mid_tx();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
